// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter emitting sync word 11011, payload MSB-first, then an idle gap
//
// Optional feature macro: SYNC_FRAME_TX_PARITY_EN
//   When defined, one even-parity bit (XOR of the payload latched at handshake)
//   follows the payload, and frame_done moves onto that bit.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   tx_data    in   payload, sampled only on the tx_valid && tx_ready edge
//   tx_valid   in   payload request
//   tx_ready   out  high while idle (combinational from state)
//   dout       out  registered serial line
//   dout_en    out  high while dout carries a sync, payload or parity bit
//   busy       out  high whenever a frame or its gap is in progress
//   frame_done out  one-cycle pulse on the last frame bit
module sync_frame_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);
  localparam int DW_B = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW_B = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CW0  = (DW_B > 3) ? DW_B : 3;
  localparam int CW   = (GW_B > CW0) ? GW_B : CW0;
`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
`ifdef SYNC_FRAME_TX_PARITY_EN
    S_PAR  = 3'd3,
`endif
    S_GAP  = 3'd4
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_dout;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic              r_par;
`endif

  assign tx_ready   = (r_state == S_IDLE);
  assign dout       = r_dout;
  assign dout_en    = r_en;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Outputs are loaded one edge ahead: each branch sets the bit to show in the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_state <= S_SYNC;
            r_shift <= tx_data;
`ifdef SYNC_FRAME_TX_PARITY_EN
            r_par   <= ^tx_data;
`endif
            r_cnt   <= '0;
            r_dout  <= 1'b1;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_dout  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
          r_done <= 1'b0;
        end
        S_SYNC: begin
          if (r_cnt == CW'(4)) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_dout  <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_done  <= !PAR_EN && (DATA_W == 1);
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            // sync word 11011: only the bit after index 1 is zero
            r_dout  <= (r_cnt != CW'(1));
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(DATA_W - 1)) begin
            r_cnt   <= '0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            r_state <= S_PAR;
            r_dout  <= r_par;
            r_done  <= 1'b1;
`else
            r_state <= S_GAP;
            r_dout  <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
`endif
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_dout  <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_done  <= !PAR_EN && (r_cnt == CW'(DATA_W - 2));
          end
        end
`ifdef SYNC_FRAME_TX_PARITY_EN
        S_PAR: begin
          r_state <= S_GAP;
          r_cnt   <= '0;
          r_dout  <= 1'b0;
          r_en    <= 1'b0;
          r_done  <= 1'b0;
        end
`endif
        S_GAP: begin
          if (r_cnt == CW'(GAP - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_dout  <= 1'b0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: randomized and directed checks of sync_frame_tx against a frame-queue reference model
module tb_sync_frame_tx;
  localparam int DW = 8;
  localparam int GP = 2;
`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, dout, dout_en, busy, frame_done;

  int vectors = 0;
  int errs = 0;
  logic [2:0] q[$];
  logic exp_ready = 1'b1;

  sync_frame_tx #(.DATA_W(DW), .GAP(GP)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dout(dout), .dout_en(dout_en), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle {dout, dout_en, frame_done} for one accepted payload, then the gap.
  task automatic push_frame(input logic [DW-1:0] d);
    logic b[$];
    b = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = DW - 1; i >= 0; i--) b.push_back(d[i]);
    if (PB == 1) b.push_back(^d);
    for (int i = 0; i < b.size(); i++) q.push_back({b[i], 1'b1, i == b.size() - 1});
    for (int i = 0; i < GP; i++) q.push_back(3'b000);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    logic hs;
    logic [2:0] e;
    logic be;
    tx_valid = v;
    tx_data  = d;
    hs = v && exp_ready;
    @(posedge clk);
    #1;
    if (hs) push_frame(d);
    if (q.size() > 0) begin
      e = q.pop_front();
      be = 1'b1;
      exp_ready = 1'b0;
    end else begin
      e = 3'b000;
      be = 1'b0;
      exp_ready = 1'b1;
    end
    chk("dout", 16'(dout), 16'(e[2]));
    chk("dout_en", 16'(dout_en), 16'(e[1]));
    chk("frame_done", 16'(frame_done), 16'(e[0]));
    chk("busy", 16'(busy), 16'(be));
    chk("tx_ready", 16'(tx_ready), 16'(exp_ready));
  endtask

  // Sends one payload and compares the first 13 line bits to a literal.
  task automatic directed(input string tag, input logic [DW-1:0] d, input logic [12:0] exp_bits);
    logic [12:0] cap;
    step(1'b1, d);
    cap[12] = dout;
    for (int i = 11; i >= 0; i--) begin
      step(1'b0, DW'($urandom));
      cap[i] = dout;
    end
    chk(tag, 16'(cap), 16'(exp_bits));
    repeat (3 + PB + GP) step(1'b0, DW'($urandom));
  endtask

  initial begin
    #3;
    chk("rst_dout", 16'(dout), 16'd0);
    chk("rst_dout_en", 16'(dout_en), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_tx_ready", 16'(tx_ready), 16'd1);
    #14 reset = 1'b1;
    repeat (20) step(1'b0, DW'($urandom));
    directed("bits_a5", 8'hA5, 13'b1101110100101);
    step(1'b1, 8'hFF);
    repeat (15) step(1'b1, DW'($urandom));
    step(1'b1, 8'h00);
    repeat (20) step(1'b1, DW'($urandom));
    repeat (20) step(1'b0, DW'($urandom));
    repeat (400) step(1'($urandom), DW'($urandom));
    repeat (20) step(1'b0, DW'($urandom));
    step(1'b1, 8'h96);
    repeat (7) step(1'b0, DW'($urandom));
    #3 reset = 1'b0;
    #1;
    chk("async_dout", 16'(dout), 16'd0);
    chk("async_dout_en", 16'(dout_en), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    chk("async_frame_done", 16'(frame_done), 16'd0);
    chk("async_tx_ready", 16'(tx_ready), 16'd1);
    q.delete();
    exp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    directed("bits_3c", 8'h3C, 13'b1101100111100);
    repeat (200) step(1'($urandom), DW'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
